// File: rtl/dxl_pkg.sv
// Shared Dynamixel protocol 1.0 definitions for the receive parser and TX packet builder.
package dxl_pkg;

    localparam logic [7:0] DXL_HDR       = 8'hFF;
    localparam int         DXL_MAX_PARAM = 4;

    typedef enum logic [2:0] {
        ST_HDR1  = 3'd0,
        ST_HDR2  = 3'd1,
        ST_ID    = 3'd2,
        ST_LEN   = 3'd3,
        ST_ERR   = 3'd4,
        ST_PARAM = 3'd5,
        ST_CHK   = 3'd6
    } dxl_rx_state_t;

    // LEN counts ERR + params + CHK, so a legal status packet has 2..max_param+2.
    function automatic logic dxl_len_ok(input logic [7:0] len, input int max_param);
        return (len >= 8'd2) && (len <= 8'(max_param + 2));
    endfunction

endpackage

// File: rtl/dxl_byte_timer.sv
// Inter-byte timeout counter. Clears on every accepted byte, counts while a packet
// is open, and flags expiry on the cycle whose clock edge brings it to TIMEOUT_CYCLES-1.
module dxl_byte_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry is seen one cycle early so the registered timeout pulse lands on the
    // edge where the count would reach TIMEOUT_CYCLES-1.
    assign o_expired = i_run && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    // Count idle cycles inside an open packet; restart on bytes, idle or expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_run || o_expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dxl_status_parser.sv
// Dynamixel protocol 1.0 status packet parser (FF FF ID LEN ERR P0..Pn CHK).
// Input handshake: a byte is consumed on any cycle with rx_valid=1 and rx_enable=1;
// there is no backpressure, and rx_enable=0 drops bytes and aborts any open packet.
// Outputs: stat_valid, chk_err, len_err and timeout_err are single-cycle registered
// pulses; stat_* hold the last good packet until the next one.
module dxl_status_parser
    import dxl_pkg::*;
#(
    parameter int MAX_PARAM      = DXL_MAX_PARAM,  // fixed by the 32-bit stat_data
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_enable,
    output logic        stat_valid,
    output logic [7:0]  stat_id,
    output logic [7:0]  stat_error,
    output logic [31:0] stat_data,
    output logic [2:0]  stat_nparam,
    output logic        chk_err,
    output logic        len_err,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);

    dxl_rx_state_t r_state;
    dxl_rx_state_t w_state_nxt;

    logic [7:0]  r_sum;
    logic [7:0]  r_id;
    logic [7:0]  r_err;
    logic [2:0]  r_len;
    logic [2:0]  r_idx;
    logic [31:0] r_shadow;

    logic [7:0]  r_stat_id;
    logic [7:0]  r_stat_error;
    logic [31:0] r_stat_data;
    logic [2:0]  r_stat_nparam;
    logic        r_stat_valid;
    logic        r_chk_err;
    logic        r_len_err;
    logic        r_timeout_err;

    logic w_accept;
    logic w_expired;
    logic w_ld_id;
    logic w_ld_len;
    logic w_ld_err;
    logic w_ld_param;
    logic w_good;
    logic w_bad_chk;
    logic w_bad_len;
    logic w_tmo;

    assign w_accept = rx_valid && rx_enable;

    dxl_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_clr     (w_accept),
        .i_run     ((r_state != ST_HDR1) && rx_enable),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HDR1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; a byte beats a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_id     = 1'b0;
        w_ld_len    = 1'b0;
        w_ld_err    = 1'b0;
        w_ld_param  = 1'b0;
        w_good      = 1'b0;
        w_bad_chk   = 1'b0;
        w_bad_len   = 1'b0;
        w_tmo       = 1'b0;
        if (!rx_enable) begin
            w_state_nxt = ST_HDR1;
        end else if (w_accept) begin
            case (r_state)
                ST_HDR1: begin
                    if (rx_data == DXL_HDR) w_state_nxt = ST_HDR2;
                end
                ST_HDR2: begin
                    w_state_nxt = (rx_data == DXL_HDR) ? ST_ID : ST_HDR1;
                end
                ST_ID: begin
                    if (rx_data != DXL_HDR) begin
                        w_ld_id     = 1'b1;
                        w_state_nxt = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (dxl_len_ok(rx_data, MAX_PARAM)) begin
                        w_ld_len    = 1'b1;
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_bad_len   = 1'b1;
                        w_state_nxt = ST_HDR1;
                    end
                end
                ST_ERR: begin
                    w_ld_err    = 1'b1;
                    w_state_nxt = (r_len == 3'd2) ? ST_CHK : ST_PARAM;
                end
                ST_PARAM: begin
                    w_ld_param = 1'b1;
                    if ((r_idx + 3'd1) == (r_len - 3'd2)) w_state_nxt = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data == ~r_sum) w_good = 1'b1;
                    else                   w_bad_chk = 1'b1;
                    w_state_nxt = ST_HDR1;
                end
                default: w_state_nxt = ST_HDR1;
            endcase
        end else if (w_expired) begin
            w_tmo       = 1'b1;
            w_state_nxt = ST_HDR1;
        end
    end

    // Packet shadow registers and modulo-256 checksum accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum    <= '0;
            r_id     <= '0;
            r_err    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            if (w_ld_id) begin
                r_id  <= rx_data;
                r_sum <= rx_data;
            end
            if (w_ld_len) begin
                r_len <= rx_data[2:0];
                r_sum <= r_sum + rx_data;
            end
            if (w_ld_err) begin
                r_err    <= rx_data;
                r_sum    <= r_sum + rx_data;
                r_shadow <= '0;
                r_idx    <= '0;
            end
            if (w_ld_param) begin
                r_shadow[r_idx[1:0]*8 +: 8] <= rx_data;
                r_sum                       <= r_sum + rx_data;
                r_idx                       <= r_idx + 3'd1;
            end
        end
    end

    // Registered outputs: publish the shadow on a good checksum, pulse fault flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_id     <= '0;
            r_stat_error  <= '0;
            r_stat_data   <= '0;
            r_stat_nparam <= '0;
            r_stat_valid  <= 1'b0;
            r_chk_err     <= 1'b0;
            r_len_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_stat_valid  <= w_good;
            r_chk_err     <= w_bad_chk;
            r_len_err     <= w_bad_len;
            r_timeout_err <= w_tmo;
            if (w_good) begin
                r_stat_id     <= r_id;
                r_stat_error  <= r_err;
                r_stat_data   <= r_shadow;
                r_stat_nparam <= r_len - 3'd2;
            end
        end
    end

    assign stat_valid  = r_stat_valid;
    assign stat_id     = r_stat_id;
    assign stat_error  = r_stat_error;
    assign stat_data   = r_stat_data;
    assign stat_nparam = r_stat_nparam;
    assign chk_err     = r_chk_err;
    assign len_err     = r_len_err;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_dxl_status_parser.sv
// Bench for dxl_status_parser: directed protocol cases plus randomly generated
// packets whose expected outcome is decided when the packet is built.
module tb_dxl_status_parser;

    localparam int TB_T = 40;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_enable;
    logic        stat_valid;
    logic [7:0]  stat_id;
    logic [7:0]  stat_error;
    logic [31:0] stat_data;
    logic [2:0]  stat_nparam;
    logic        chk_err;
    logic        len_err;
    logic        timeout_err;
    logic [2:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int c_v, c_c, c_l, c_t;

    // Reference: last good packet as seen by the bench.
    logic [7:0]  m_id, m_err;
    logic [31:0] m_data;
    logic [2:0]  m_np;

    dxl_status_parser #(
        .TIMEOUT_CYCLES (TB_T)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_enable   (rx_enable),
        .stat_valid  (stat_valid),
        .stat_id     (stat_id),
        .stat_error  (stat_error),
        .stat_data   (stat_data),
        .stat_nparam (stat_nparam),
        .chk_err     (chk_err),
        .len_err     (len_err),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (stat_valid)  c_v++;
        if (chk_err)     c_c++;
        if (len_err)     c_l++;
        if (timeout_err) c_t++;
    endtask

    task automatic clr_counts();
        c_v = 0; c_c = 0; c_l = 0; c_t = 0;
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input bq_t q);
        foreach (q[i]) put(q[i]);
    endtask

    task automatic check_counts(input string tag, input int v, input int c, input int l, input int t);
        check({tag, "_nvalid"}, c_v, v);
        check({tag, "_nchk"},   c_c, c);
        check({tag, "_nlen"},   c_l, l);
        check({tag, "_ntmo"},   c_t, t);
    endtask

    task automatic check_stat(input string tag);
        check({tag, "_id"},     stat_id,     m_id);
        check({tag, "_err"},    stat_error,  m_err);
        check({tag, "_data"},   stat_data,   m_data);
        check({tag, "_nparam"}, stat_nparam, m_np);
    endtask

    // Builds a packet from ID/ERR/params; checksum is the inverted byte sum.
    function automatic bq_t build(input logic [7:0] id, input logic [7:0] err, input bq_t prm);
        bq_t q;
        logic [7:0] s;
        q = '{8'hFF, 8'hFF, id, 8'(prm.size() + 2), err};
        s = id + 8'(prm.size() + 2) + err;
        foreach (prm[i]) begin
            q.push_back(prm[i]);
            s = s + prm[i];
        end
        q.push_back(~s);
        return q;
    endfunction

    task automatic rand_pkt();
        int kind, np, sel;
        logic [7:0] id, len, err, p, s, ck;
        logic [31:0] data;
        kind = int'($urandom_range(0, 2));
        np   = int'($urandom_range(0, 4));
        repeat ($urandom_range(0, 2)) put(8'($urandom_range(0, 254)));
        clr_counts();
        put(8'hFF);
        put(8'hFF);
        if ($urandom_range(0, 1) == 1) put(8'hFF);
        id = 8'($urandom_range(0, 254));
        put(id);
        idle(int'($urandom_range(0, 2)));
        if (kind == 2) begin
            sel = int'($urandom_range(0, 2));
            len = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : 8'($urandom_range(7, 255));
            put(len);
            check("rnd_len_err_pulse", len_err, 1'b1);
            idle(1);
            check_counts("rnd_badlen", 0, 0, 1, 0);
            check_stat("rnd_badlen");
            return;
        end
        len = 8'(np + 2);
        err = 8'($urandom);
        put(len);
        put(err);
        s = id + len + err;
        data = '0;
        for (int i = 0; i < np; i++) begin
            p = 8'($urandom);
            put(p);
            idle(int'($urandom_range(0, 2)));
            data[i*8 +: 8] = p;
            s = s + p;
        end
        ck = ~s;
        if (kind == 1) ck = ck ^ 8'($urandom_range(1, 255));
        put(ck);
        if (kind == 0) begin
            check("rnd_valid_pulse", stat_valid, 1'b1);
            m_id = id; m_err = err; m_data = data; m_np = 3'(np);
        end else begin
            check("rnd_chk_pulse", chk_err, 1'b1);
        end
        idle(1);
        if (kind == 0) check_counts("rnd_good", 1, 0, 0, 0);
        else           check_counts("rnd_badchk", 0, 1, 0, 0);
        check_stat("rnd");
    endtask

    initial begin
        bq_t pk1, pk2, pk1_bad, prm;
        reset_n   = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_enable = 1'b1;
        m_id = '0; m_err = '0; m_data = '0; m_np = '0;
        clr_counts();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid", stat_valid, 1'b0);
        check("rst_chk",   chk_err, 1'b0);
        check("rst_len",   len_err, 1'b0);
        check("rst_tmo",   timeout_err, 1'b0);
        check_stat("rst");
        reset_n = 1'b1;
        idle(2);

        prm = {};
        pk1 = build(8'h01, 8'h00, prm);
        prm = '{8'h11, 8'h22, 8'h33, 8'h44};
        pk2 = build(8'h03, 8'h20, prm);
        pk1_bad = pk1;
        pk1_bad[5] = 8'hFD;

        // Minimal packet, no parameters.
        clr_counts();
        check("pk1_chk_byte", pk1[5], 8'hFC);
        send(pk1);
        check("pk1_valid_pulse", stat_valid, 1'b1);
        m_id = 8'h01; m_err = 8'h00; m_data = 32'h0; m_np = 3'd0;
        idle(1);
        check_counts("pk1", 1, 0, 0, 0);
        check_stat("pk1");

        // Four parameters, little-endian packing.
        clr_counts();
        check("pk2_chk_byte", pk2[9], 8'h2C);
        send(pk2);
        check("pk2_valid_pulse", stat_valid, 1'b1);
        m_id = 8'h03; m_err = 8'h20; m_data = 32'h44332211; m_np = 3'd4;
        idle(1);
        check_counts("pk2", 1, 0, 0, 0);
        check_stat("pk2");

        // Bad checksum keeps previous outputs; next good packet parses.
        clr_counts();
        send(pk1_bad);
        check("badchk_pulse", chk_err, 1'b1);
        idle(1);
        check_counts("badchk", 0, 1, 0, 0);
        check_stat("badchk");
        clr_counts();
        send(pk1);
        m_id = 8'h01; m_err = 8'h00; m_data = 32'h0; m_np = 3'd0;
        idle(1);
        check_counts("after_badchk", 1, 0, 0, 0);
        check_stat("after_badchk");

        // Bad LEN, following bytes ignored until a new header.
        clr_counts();
        put(8'hFF); put(8'hFF); put(8'h01); put(8'h07);
        check("badlen_pulse", len_err, 1'b1);
        put(8'h00); put(8'h11); put(8'h22); put(8'hFC);
        idle(2);
        check_counts("badlen", 0, 0, 1, 0);
        check_stat("badlen");
        clr_counts();
        send(pk2);
        m_id = 8'h03; m_err = 8'h20; m_data = 32'h44332211; m_np = 3'd4;
        idle(1);
        check_counts("after_badlen", 1, 0, 0, 0);
        check_stat("after_badlen");

        // Timeout: pulse exactly TB_T-1 cycles after the last byte.
        clr_counts();
        put(8'hFF); put(8'hFF); put(8'h01);
        idle(TB_T - 2);
        check("tmo_early", timeout_err, 1'b0);
        idle(1);
        check("tmo_pulse", timeout_err, 1'b1);
        idle(1);
        check("tmo_width", timeout_err, 1'b0);
        put(8'h02); put(8'h00); put(8'hFC);
        idle(2);
        check_counts("tmo", 0, 0, 0, 1);
        check_stat("tmo");

        // Byte on the expiry cycle wins; packet completes.
        clr_counts();
        put(8'hFF); put(8'hFF); put(8'h01);
        idle(TB_T - 2);
        put(8'h02);
        check("tmo_race_nopulse", timeout_err, 1'b0);
        put(8'h00); put(8'hFC);
        check("tmo_race_valid", stat_valid, 1'b1);
        m_id = 8'h01; m_err = 8'h00; m_data = 32'h0; m_np = 3'd0;
        idle(TB_T + 5);
        check_counts("tmo_race", 1, 0, 0, 0);
        check_stat("tmo_race");

        // rx_enable low: whole packet ignored; dropping mid-packet aborts it.
        clr_counts();
        rx_enable = 1'b0;
        send(pk2);
        rx_enable = 1'b1;
        idle(2);
        put(8'hFF); put(8'hFF); put(8'h03); put(8'h06);
        rx_enable = 1'b0;
        idle(1);
        rx_enable = 1'b1;
        put(8'h20); put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h2C);
        idle(TB_T + 5);
        check_counts("rxen", 0, 0, 0, 0);
        check_stat("rxen");

        // Random packets.
        for (int k = 0; k < 40; k++) begin
            rand_pkt();
            idle(int'($urandom_range(0, 3)));
        end

        // Reset mid-packet: outputs clear immediately, partial packet discarded.
        clr_counts();
        send(pk2);
        m_id = 8'h03; m_err = 8'h20; m_data = 32'h44332211; m_np = 3'd4;
        idle(1);
        check_stat("pre_rst");
        put(8'hFF); put(8'hFF); put(8'h03); put(8'h06); put(8'h20);
        #2 reset_n = 1'b0;
        #1;
        m_id = '0; m_err = '0; m_data = '0; m_np = '0;
        check_stat("async_rst");
        idle(2);
        reset_n = 1'b1;
        put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h2C);
        idle(TB_T + 5);
        check_counts("mid_rst", 1, 0, 0, 0);
        check_stat("mid_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dxl_status_parser.md
# dxl_status_parser

Receive-side stage of the Dynamixel link. It consumes the byte stream from the UART byte receiver behind `UART_Dynamixel` (RXD path) and parses Dynamixel protocol 1.0 status packets (`FF FF ID LEN ERR P0..Pn CHK`). For each well-formed packet it presents the servo ID, error byte and up to four parameter bytes packed into a 32-bit word for the top-level sequencer FSM. It also reports checksum, length and inter-byte timeout faults.

## Interface
Parameters:
- `MAX_PARAM`, 4: maximum parameter bytes accepted; fixed at 4 by the 32-bit `stat_data` width.
- `TIMEOUT_CYCLES`, 50000: maximum clock cycles between consecutive bytes inside a packet (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock, 50 MHz (`CLOCK_50`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `rx_enable`  in  1  high when the half-duplex line is in receive direction (the inverse of `uart_dir`).
- `stat_valid`  out  1  one-cycle pulse; the `stat_*` outputs hold a new good packet.
- `stat_id`  out  8  servo ID.
- `stat_error`  out  8  Dynamixel error byte.
- `stat_data`  out  32  parameters, little-endian (P0 in [7:0]); unused bytes are 0.
- `stat_nparam`  out  3  number of parameters, LEN−2, range 0..4.
- `chk_err`  out  1  one-cycle pulse on a checksum mismatch.
- `len_err`  out  1  one-cycle pulse when LEN<2 or LEN>MAX_PARAM+2.
- `timeout_err`  out  1  one-cycle pulse on an inter-byte timeout.

## Operation
- States: `HDR1`, `HDR2`, `ID`, `LEN`, `ERR`, `PARAM`, `CHK`. Reset state is `HDR1`.
- Every transition below is taken only on a cycle with `rx_valid=1` and `rx_enable=1`.
- `HDR1`: byte FF → `HDR2`. Any other byte → stay in `HDR1`.
- `HDR2`: byte FF → `ID`. Any other byte → `HDR1`.
- `ID`: byte FF is treated as an extra header byte → stay in `ID`. Any other byte → latch ID, sum=ID, go to `LEN`.
- `LEN`: if 2 ≤ LEN ≤ MAX_PARAM+2 → latch LEN, sum+=LEN, go to `ERR`. Otherwise pulse `len_err` → `HDR1`.
- `ERR`: latch the error byte, sum+=ERR, clear the parameter shadow. If LEN=2 → `CHK`, else → `PARAM`.
- `PARAM`: write the byte into shadow lane `idx`, sum+=byte, idx++. When idx reaches LEN−2 → `CHK`.
- `CHK`: if byte == ~sum[7:0], copy the shadow registers to the `stat_*` outputs and pulse `stat_valid`. Otherwise pulse `chk_err` and leave `stat_*` unchanged. Next state is `HDR1` in both cases.
- Checksum arithmetic: `sum` is an 8-bit accumulator; overflow is discarded (modulo 256).
- `rx_enable=0`: bytes are ignored and the FSM is forced to `HDR1` synchronously. No error is flagged. This discards TX echo.
- Timeout: a counter clears on every accepted byte and increments while state ≠ `HDR1`. When it reaches TIMEOUT_CYCLES−1, the FSM goes to `HDR1` and `timeout_err` pulses. No timeout is ever raised in `HDR1`.
- Simultaneous byte and timeout expiry: the byte wins. It is processed and the counter clears.
- Reset values: state `HDR1`; all `stat_*` outputs 0; all pulse outputs 0; counter, sum and idx 0.
- Reset asserted mid-packet: the partial packet is discarded and the outputs return to their reset values immediately.

## Timing
- Every output is registered.
- `stat_valid`, `chk_err` and `len_err` assert on the clock edge that samples the relevant `rx_valid` byte. They are visible 1 cycle after the strobe and are high for exactly 1 cycle.
- `stat_*` data outputs change only in the same cycle `stat_valid` rises, and hold until the next good packet.
- The block accepts one byte per cycle; back-to-back `rx_valid` strobes are legal. There is no backpressure.
- `timeout_err` rises exactly TIMEOUT_CYCLES−1 cycles after the last accepted byte if no byte arrives in between.

## Structure
- Shared package `dxl_pkg`: state enum `dxl_rx_state_t`, constant `DXL_HDR = 8'hFF`, and `DXL_MAX_PARAM = 4`. The pkg is also reused by the TX packet builder.
- One natural sub-module, `dxl_byte_timer`: the inter-byte timeout counter, with `clr`, `run` and `expired`.
- The FSM, checksum accumulator and parameter shadow registers stay in the top module.

## Test plan
- Send `FF FF 01 02 00 FC` → `stat_valid` pulses; `stat_id`=01, `stat_error`=00, `stat_nparam`=0, `stat_data`=0.
- Send `FF FF 03 06 20 11 22 33 44 ~(03+06+20+11+22+33+44)` → `stat_data`=44332211, `stat_error`=20, `stat_nparam`=4.
- Send the first packet with the last byte FD → `chk_err` pulses once; `stat_*` keep their previous values; the next good packet is parsed normally.
- Send `FF FF 01 07 ...` → `len_err` pulses on the LEN byte; following bytes are ignored until a new `FF FF`.
- Send `FF FF 01`, then wait TIMEOUT_CYCLES−1 cycles → `timeout_err` pulses. Repeat with the byte arriving on the expiry cycle → no `timeout_err`.
- Send a valid packet with `rx_enable=0`, then deassert `reset_n` mid-packet → no outputs pulse, and all outputs read 0 after reset.
